// File: rtl/ntt_butterfly_param.sv
// ntt_butterfly_param: pipelined CT/GS NTT butterfly with Montgomery multiply, latency MONT_STAGES+2.
// Define NTT_BF_HALVE_EN to add the halve input (GS outputs scaled by 2^-1 mod Q).
module ntt_butterfly_param #(
  parameter int WIDTH = 16,
  parameter int Q = 12289,
  parameter int R_BITS = 18,
  parameter int QINV = 12287,
  parameter int MONT_STAGES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic             mode,
`ifdef NTT_BF_HALVE_EN
  input  logic             halve,
`endif
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [WIDTH-1:0] omega,
  output logic [WIDTH-1:0] outa,
  output logic [WIDTH-1:0] outb,
  output logic             out_valid
);
  localparam int MS = MONT_STAGES;
  localparam int W1 = WIDTH + 1;
  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + R_BITS + 1;
  localparam int TW = SW - R_BITS;
  localparam logic [W1-1:0] QW = W1'(Q);
  localparam logic [SW-1:0] QS = SW'(Q);
  localparam logic [TW-1:0] QT = TW'(Q);
  localparam logic [R_BITS-1:0] QI = R_BITS'(QINV);
  function automatic logic [WIDTH-1:0] add_q(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [W1-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return WIDTH'(s >= QW ? s - QW : s);
  endfunction
  function automatic logic [WIDTH-1:0] sub_q(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [W1-1:0] d;
    d = {1'b0, a} - {1'b0, b};
    return WIDTH'(d[WIDTH] ? d + QW : d);
  endfunction
`ifdef NTT_BF_HALVE_EN
  function automatic logic [WIDTH-1:0] half(input logic [WIDTH-1:0] x);
    return x[0] ? WIDTH'(({1'b0, x} + QW) >> 1) : x >> 1;
  endfunction
  logic h0;
  logic h_s [MS];
`endif
  logic [WIDTH-1:0] a0, b0, w0;
  logic m0, v0;
  logic [PW-1:0] x_s [MS];
  logic [R_BITS-1:0] u_s [MS-1];
  logic [WIDTH-1:0] c_s [MS];
  logic m_s [MS];
  logic v_s [MS];
  logic [WIDTH-1:0] mop, cin, t, ra, rb;
  logic [TW-1:0] tw;
  // GS does its add/sub ahead of the multiplier; c_s carries a (CT) or a+b (GS) alongside the product
  always_comb begin
    mop = m0 ? sub_q(a0, b0) : b0;
    cin = m0 ? add_q(a0, b0) : a0;
    tw = TW'((SW'(x_s[MS-1]) + SW'(u_s[MS-2]) * QS) >> R_BITS);
    t = WIDTH'(tw >= QT ? tw - QT : tw);
    ra = m_s[MS-1] ? c_s[MS-1] : add_q(c_s[MS-1], t);
    rb = m_s[MS-1] ? t : sub_q(c_s[MS-1], t);
`ifdef NTT_BF_HALVE_EN
    if (m_s[MS-1] && h_s[MS-1]) begin
      ra = half(ra);
      rb = half(rb);
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v0 <= 1'b0;
      for (int i = 0; i < MS; i++) v_s[i] <= 1'b0;
      out_valid <= 1'b0;
      outa <= '0;
      outb <= '0;
    end else if (en) begin
      a0 <= ina;
      b0 <= inb;
      w0 <= omega;
      m0 <= mode;
      v0 <= in_valid;
      x_s[0] <= PW'(mop) * PW'(w0);
      c_s[0] <= cin;
      m_s[0] <= m0;
      v_s[0] <= v0;
      u_s[0] <= x_s[0][R_BITS-1:0] * QI;
      for (int i = 1; i < MS; i++) begin
        x_s[i] <= x_s[i-1];
        c_s[i] <= c_s[i-1];
        m_s[i] <= m_s[i-1];
        v_s[i] <= v_s[i-1];
      end
      for (int i = 1; i < MS - 1; i++) u_s[i] <= u_s[i-1];
`ifdef NTT_BF_HALVE_EN
      h0 <= halve;
      h_s[0] <= h0;
      for (int i = 1; i < MS; i++) h_s[i] <= h_s[i-1];
`endif
      outa <= ra;
      outb <= rb;
      out_valid <= v_s[MS-1];
    end
  end
endmodule

// File: tb/tb_ntt_butterfly_param.sv
// tb_ntt_butterfly_param: directed self-checking bench for ntt_butterfly_param (Q=12289, LAT=5).
module tb_ntt_butterfly_param;
  localparam int W = 16;
  localparam int Q = 12289;
  localparam int LAT = 5;
  logic clk = 0, reset = 1, en = 1, in_valid = 0, mode = 0;
  logic [W-1:0] ina = 0, inb = 0, omega = 0;
  logic [W-1:0] outa, outb;
  logic out_valid;
`ifdef NTT_BF_HALVE_EN
  logic halve = 0;
`endif
  int vecs = 0, errs = 0;
  longint rinv = 0;

  always #5 clk = ~clk;

  ntt_butterfly_param dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .mode(mode),
`ifdef NTT_BF_HALVE_EN
    .halve(halve),
`endif
    .ina(ina), .inb(inb), .omega(omega),
    .outa(outa), .outb(outb), .out_valid(out_valid)
  );

  function automatic void model(input logic m, input longint a, input longint b, input longint w,
                                output logic [W-1:0] ea, output logic [W-1:0] eb);
    longint t;
    if (m) begin
      t = ((a - b + Q) % Q) * w % Q * rinv % Q;
      ea = W'((a + b) % Q);
      eb = W'(t);
    end else begin
      t = b * w % Q * rinv % Q;
      ea = W'((a + t) % Q);
      eb = W'((a - t + Q) % Q);
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input int a, input int b, input int w);
    in_valid = v;
    mode = m;
    ina = W'(a);
    inb = W'(b);
    omega = W'(w);
  endtask

  task automatic test_reset;
    reset = 1; en = 0; in_valid = 1;
    tick; tick;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    vecs++; if (outa !== 0 || outb !== 0) begin errs++; $display("FAIL reset_out got %0d/%0d want 0/0", outa, outb); end
    reset = 0; en = 1; in_valid = 0;
  endtask

  task automatic test_latency;
    drive(1, 0, 100, 200, 4075);
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (c == 1) in_valid = 0;
      vecs++;
      if (out_valid !== (c == LAT)) begin errs++; $display("FAIL latency_valid cyc %0d got %0b want %0b", c, out_valid, c == LAT); end
      if (c == LAT) begin
        vecs++;
        if (outa !== 300 || outb !== 12189) begin errs++; $display("FAIL latency_data got %0d/%0d want 300/12189", outa, outb); end
      end
    end
  endtask

  task automatic test_gs_ct;
    drive(1, 1, 100, 200, 4075); tick;
    drive(1, 0, 12000, 500, 4075); tick;
    in_valid = 0;
    tick; tick; tick;
    vecs++;
    if (out_valid !== 1'b1 || outa !== 300 || outb !== 12189) begin
      errs++; $display("FAIL gs_wrap got v=%0b %0d/%0d want v=1 300/12189", out_valid, outa, outb);
    end
    tick;
    vecs++;
    if (out_valid !== 1'b1 || outa !== 211 || outb !== 11500) begin
      errs++; $display("FAIL ct_wrap got v=%0b %0d/%0d want v=1 211/11500", out_valid, outa, outb);
    end
    tick;
  endtask

  task automatic test_interleave;
    logic [W-1:0] ea [20];
    logic [W-1:0] eb [20];
    for (int c = 0; c < 20 + LAT + 2; c++) begin
      int a, b, w, k;
      logic ev;
      if (c < 20) begin
        a = int'($urandom_range(Q - 1));
        b = int'($urandom_range(Q - 1));
        w = int'($urandom_range(Q - 1));
        drive(1, c[0], a, b, w);
        model(c[0], a, b, w, ea[c], eb[c]);
      end else in_valid = 0;
      tick;
      k = c - (LAT - 1);
      ev = (k >= 0 && k < 20);
      vecs++;
      if (out_valid !== ev) begin errs++; $display("FAIL interleave_valid cyc %0d got %0b want %0b", c, out_valid, ev); end
      if (ev) begin
        vecs++;
        if (outa !== ea[k] || outb !== eb[k]) begin
          errs++; $display("FAIL interleave_data #%0d got %0d/%0d want %0d/%0d", k, outa, outb, ea[k], eb[k]);
        end
      end
    end
  endtask

  task automatic test_zero_twiddle;
    drive(1, 0, 7, 1234, 0); tick;
    in_valid = 0;
    tick; tick; tick; tick;
    vecs++;
    if (out_valid !== 1'b1 || outa !== 7 || outb !== 7) begin
      errs++; $display("FAIL zero_twiddle got v=%0b %0d/%0d want v=1 7/7", out_valid, outa, outb);
    end
    tick;
  endtask

  task automatic test_stall;
    logic [63:0] pat;
    int sa [8], sb [8], sw [8];
    logic sm [8];
    logic [W-1:0] ea [8], eb [8], pa, pb;
    logic pv;
    int sent, got;
    pat = 64'hB5A3_96C7_4E2D_1F89;
    sent = 0; got = 0;
    for (int i = 0; i < 8; i++) begin
      sa[i] = int'($urandom_range(Q - 1));
      sb[i] = int'($urandom_range(Q - 1));
      sw[i] = int'($urandom_range(Q - 1));
      sm[i] = i[1] ^ i[0];
      model(sm[i], sa[i], sb[i], sw[i], ea[i], eb[i]);
    end
    for (int c = 0; c < 64 && got < 8; c++) begin
      en = pat[c];
      if (sent < 8) drive(1, sm[sent], sa[sent], sb[sent], sw[sent]);
      else in_valid = 0;
      pa = outa; pb = outb; pv = out_valid;
      tick;
      if (en && sent < 8) sent++;
      if (!en) begin
        vecs++;
        if (outa !== pa || outb !== pb || out_valid !== pv) begin
          errs++; $display("FAIL stall_hold cyc %0d got v=%0b %0d/%0d want v=%0b %0d/%0d", c, out_valid, outa, outb, pv, pa, pb);
        end
      end else if (out_valid) begin
        vecs++;
        if (got >= 8) begin errs++; $display("FAIL stall_extra got %0d outputs want 8", got + 1); end
        else if (outa !== ea[got] || outb !== eb[got]) begin
          errs++; $display("FAIL stall_data #%0d got %0d/%0d want %0d/%0d", got, outa, outb, ea[got], eb[got]);
        end
        got++;
      end
    end
    en = 1; in_valid = 0;
    vecs++;
    if (got !== 8) begin errs++; $display("FAIL stall_count got %0d want 8", got); end
  endtask

`ifdef NTT_BF_HALVE_EN
  task automatic test_halve;
    drive(1, 1, 1, 0, 4075); halve = 1; tick;
    halve = 0; tick;
    drive(1, 0, 1, 0, 4075); halve = 1; tick;
    in_valid = 0; halve = 0;
    tick; tick;
    vecs++;
    if (out_valid !== 1'b1 || outa !== 6145 || outb !== 6145) begin
      errs++; $display("FAIL halve_on got v=%0b %0d/%0d want v=1 6145/6145", out_valid, outa, outb);
    end
    tick;
    vecs++;
    if (out_valid !== 1'b1 || outa !== 1 || outb !== 1) begin
      errs++; $display("FAIL halve_off got v=%0b %0d/%0d want v=1 1/1", out_valid, outa, outb);
    end
    tick;
    vecs++;
    if (out_valid !== 1'b1 || outa !== 1 || outb !== 1) begin
      errs++; $display("FAIL halve_ct got v=%0b %0d/%0d want v=1 1/1", out_valid, outa, outb);
    end
    tick;
  endtask
`endif

  task automatic test_reset_mid;
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 100 + i, 5, 4075);
      tick;
    end
    in_valid = 0; reset = 1;
    tick;
    reset = 0;
    vecs++;
    if (out_valid !== 1'b0 || outa !== 0 || outb !== 0) begin
      errs++; $display("FAIL reset_mid got v=%0b %0d/%0d want v=0 0/0", out_valid, outa, outb);
    end
    for (int c = 0; c < 10; c++) begin
      tick;
      vecs++;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_stale cyc %0d got v=%0b want 0", c, out_valid); end
    end
  endtask

  initial begin
    longint r;
    r = (64'd1 << 18) % Q;
    for (longint k = 1; k < Q; k++) if ((r * k) % Q == 1) rinv = k;
    tick;
    test_reset;
    test_latency;
    test_gs_ct;
    test_interleave;
    test_zero_twiddle;
    test_stall;
`ifdef NTT_BF_HALVE_EN
    test_halve;
`endif
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
